// File: rtl/magic_buttons.sv
// magic_buttons: request-input conditioner for the magic/NMI controller.
// Synchronises and debounces the MAGIC/PAUSE board buttons, stretches the
// keyboard hotkey pulses across frame-interrupt boundaries, and raises a
// one-cycle reboot request after a long MAGIC press.
module magic_buttons #(
  parameter int unsigned DEBOUNCE_CYCLES  = 28000,
  parameter int unsigned HOTKEY_FRAMES    = 2,
  parameter int unsigned LONGPRESS_FRAMES = 100
) (
  input  logic clk28,
  input  logic rst,
  input  logic n_int,
  input  logic btn_magic_n,
  input  logic btn_pause_n,
  input  logic key_magic,
  input  logic key_pause,
  output logic magic_button,
  output logic pause_button,
  output logic reboot_req
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HK_W = $clog2(HOTKEY_FRAMES + 1);
  localparam int unsigned LP_W = $clog2(LONGPRESS_FRAMES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HK_W-1:0] HK_LOAD = HK_W'(HOTKEY_FRAMES);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONGPRESS_FRAMES);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONGPRESS_FRAMES - 1);

  // Channel 0 = MAGIC, channel 1 = PAUSE.
  logic [1:0] w_raw_n;
  logic [1:0] w_key;
  logic [1:0] w_stable_n;
  logic [1:0] w_button;
  logic       w_frame_tick;

  logic            r_n_int_d;
  logic [LP_W-1:0] r_lp_cnt;
  logic            r_reboot;

  assign w_raw_n = {btn_pause_n, btn_magic_n};
  assign w_key   = {key_pause, key_magic};

  // Frame-interrupt edge detector: previous n_int level.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) r_n_int_d <= 1'b1;
    else     r_n_int_d <= n_int;
  end

  assign w_frame_tick = r_n_int_d & ~n_int;

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable_n;
    logic [DB_W-1:0] r_db_cnt;
    logic [HK_W-1:0] r_hold;
    logic            r_button;
    logic            w_hold_active;

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
      end else begin
        r_sync1 <= w_raw_n[g];
        r_sync2 <= r_sync1;
      end
    end

    // Debounce: stable level flips only after an unbroken run of differing samples.
    always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
        r_stable_n <= 1'b1;
        r_db_cnt   <= '0;
      end else if (r_sync2 == r_stable_n) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_stable_n <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

    // Hotkey hold: a pulse (re)loads the frame count, frame ticks drain it.
    always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
        r_hold <= '0;
      end else if (w_key[g]) begin
        r_hold <= HK_LOAD;
      end else if (w_frame_tick && (r_hold != '0)) begin
        r_hold <= r_hold - 1'b1;
      end
    end

    // Hold is active while any frames remain.
    always_comb begin
      w_hold_active = (r_hold != '0);
    end

    // Registered request level: debounced press OR hotkey hold.
    always_ff @(posedge clk28 or posedge rst) begin
      if (rst) r_button <= 1'b0;
      else     r_button <= ~r_stable_n | w_hold_active;
    end

    assign w_stable_n[g] = r_stable_n;
    assign w_button[g]   = r_button;
  end

  // Long press: count frame ticks while MAGIC is held, pulse once on reaching the limit.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_lp_cnt <= '0;
      r_reboot <= 1'b0;
    end else if (w_stable_n[0]) begin
      r_lp_cnt <= '0;
      r_reboot <= 1'b0;
    end else begin
      r_reboot <= w_frame_tick && (r_lp_cnt == LP_LAST);
      if (w_frame_tick && (r_lp_cnt != LP_MAX)) r_lp_cnt <= r_lp_cnt + 1'b1;
    end
  end

  assign magic_button = w_button[0];
  assign pause_button = w_button[1];
  assign reboot_req   = r_reboot;

endmodule

// File: tb/tb_magic_buttons.sv
// tb_magic_buttons: directed stimulus with a frame-count based reference model
// compared every cycle, plus hand-computed timing checks.
module tb_magic_buttons;

  localparam int DEB = 8;
  localparam int HK  = 2;
  localparam int LP  = 3;

  logic clk28       = 1'b0;
  logic rst         = 1'b1;
  logic n_int       = 1'b1;
  logic btn_magic_n = 1'b0;
  logic btn_pause_n = 1'b1;
  logic key_magic   = 1'b0;
  logic key_pause   = 1'b0;
  logic magic_button;
  logic pause_button;
  logic reboot_req;

  int errors = 0;
  int checks = 0;
  int phase  = 0;

  magic_buttons #(
    .DEBOUNCE_CYCLES (DEB),
    .HOTKEY_FRAMES   (HK),
    .LONGPRESS_FRAMES(LP)
  ) dut (
    .clk28       (clk28),
    .rst         (rst),
    .n_int       (n_int),
    .btn_magic_n (btn_magic_n),
    .btn_pause_n (btn_pause_n),
    .key_magic   (key_magic),
    .key_pause   (key_pause),
    .magic_button(magic_button),
    .pause_button(pause_button),
    .reboot_req  (reboot_req)
  );

  always #5 clk28 = ~clk28;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame interrupt: low for one cycle out of every 64.
  initial begin
    forever begin
      @(posedge clk28);
      #1;
      phase = (phase + 1) % 64;
      n_int = (phase == 63) ? 1'b0 : 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Index 0 = MAGIC, 1 = PAUSE. Holds and long press are tracked as
  // "frame ticks elapsed since event" against a global frame counter.
  int m_gtick;
  bit m_ni_prev;
  bit m_h1 [2];
  bit m_h2 [2];
  bit m_pressed [2];
  int m_run [2];
  bit m_hvalid [2];
  int m_hbase [2];
  int m_lpbase;
  bit exp_btn [2];
  bit exp_reboot;

  task automatic model_reset();
    m_gtick   = 0;
    m_ni_prev = 1'b1;
    m_lpbase  = 0;
    exp_reboot = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_h1[i] = 1'b1;
      m_h2[i] = 1'b1;
      m_pressed[i] = 1'b0;
      m_run[i] = 0;
      m_hvalid[i] = 1'b0;
      m_hbase[i] = 0;
      exp_btn[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit raw [2];
    bit key [2];
    bit old_pressed [2];
    bit old_hold [2];
    bit tick;
    bit sync_seen;
    raw[0] = btn_magic_n;
    raw[1] = btn_pause_n;
    key[0] = key_magic;
    key[1] = key_pause;
    tick = m_ni_prev && !n_int;
    m_ni_prev = n_int;
    for (int i = 0; i < 2; i++) begin
      old_pressed[i] = m_pressed[i];
      old_hold[i] = m_hvalid[i] && ((m_gtick - m_hbase[i]) < HK);
    end
    if (tick) m_gtick++;
    for (int i = 0; i < 2; i++) exp_btn[i] = old_pressed[i] | old_hold[i];
    exp_reboot = old_pressed[0] && tick && ((m_gtick - m_lpbase) == LP);
    for (int i = 0; i < 2; i++) begin
      sync_seen = m_h2[i];
      m_h2[i] = m_h1[i];
      m_h1[i] = raw[i];
      if ((!sync_seen) != m_pressed[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_pressed[i] = !sync_seen;
          m_run[i] = 0;
          if (i == 0 && m_pressed[0]) m_lpbase = m_gtick;
        end
      end else begin
        m_run[i] = 0;
      end
      if (key[i]) begin
        m_hvalid[i] = 1'b1;
        m_hbase[i] = m_gtick;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk28 or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk28);
      chk("magic_button", magic_button, exp_btn[0]);
      chk("pause_button", pause_button, exp_btn[1]);
      chk("reboot_req", reboot_req, exp_reboot);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk28);
      #2;
    end
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (phase != p && n < 200) begin
      cyc(1);
      n++;
    end
    chk("wait_phase_reached", phase, p);
  endtask

  initial begin
    bit seen;
    int ticks;
    int pulses;
    int ptick;

    // 1: reset values, then MAGIC held through reset rises 11 cycles after release
    cyc(3);
    chk("rst_magic", magic_button, 0);
    chk("rst_pause", pause_button, 0);
    chk("rst_reboot", reboot_req, 0);
    rst = 1'b0;
    cyc(10);
    chk("t1_magic_at10", magic_button, 0);
    cyc(1);
    chk("t1_magic_at11", magic_button, 1);
    btn_magic_n = 1'b1;
    cyc(15);
    chk("t1_magic_released", magic_button, 0);

    // 2: bounce then clean press, then a too-short pulse
    btn_pause_n = 1'b0;
    cyc(5);
    btn_pause_n = 1'b1;
    cyc(1);
    btn_pause_n = 1'b0;
    cyc(10);
    chk("t2_pause_at10", pause_button, 0);
    cyc(1);
    chk("t2_pause_at11", pause_button, 1);
    btn_pause_n = 1'b1;
    cyc(15);
    chk("t2_pause_released", pause_button, 0);
    btn_pause_n = 1'b0;
    cyc(7);
    btn_pause_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      cyc(1);
      seen |= pause_button;
    end
    chk("t2_short_pulse_ignored", seen, 0);

    // 3: hotkey 10 cycles before a tick holds through the second tick
    wait_phase(53);
    key_magic = 1'b1;
    cyc(1);
    key_magic = 1'b0;
    cyc(1);
    chk("t3_magic_rise", magic_button, 1);
    cyc(73);
    chk("t3_magic_at_tick2", magic_button, 1);
    cyc(1);
    chk("t3_magic_fall", magic_button, 0);

    // 4: second hotkey one cycle before a tick reloads the hold
    wait_phase(40);
    key_pause = 1'b1;
    cyc(1);
    key_pause = 1'b0;
    cyc(30);
    wait_phase(62);
    key_pause = 1'b1;
    cyc(1);
    key_pause = 1'b0;
    cyc(2);
    chk("t4_pause_after_reload", pause_button, 1);
    cyc(63);
    chk("t4_pause_at_tick2", pause_button, 1);
    cyc(1);
    chk("t4_pause_fall", pause_button, 0);

    // simultaneous buttons plus hotkey overlap
    wait_phase(10);
    btn_magic_n = 1'b0;
    btn_pause_n = 1'b0;
    cyc(12);
    chk("sim_magic_both", magic_button, 1);
    chk("sim_pause_both", pause_button, 1);
    key_magic = 1'b1;
    cyc(1);
    key_magic = 1'b0;
    btn_magic_n = 1'b1;
    cyc(15);
    chk("sim_magic_held_by_key", magic_button, 1);
    chk("sim_pause_still", pause_button, 1);
    btn_pause_n = 1'b1;
    cyc(15);
    chk("sim_pause_released", pause_button, 0);
    chk("sim_magic_still_key", magic_button, 1);
    cyc(120);
    chk("sim_magic_hold_done", magic_button, 0);

    // 5: long press fires once on the 3rd tick, then once more after re-press
    wait_phase(5);
    btn_magic_n = 1'b0;
    ticks = 0;
    pulses = 0;
    ptick = 0;
    repeat (5 * 64) begin
      cyc(1);
      if (phase == 0) ticks++;
      if (reboot_req) begin
        pulses++;
        ptick = ticks;
      end
    end
    chk("t5_pulse_count", pulses, 1);
    chk("t5_pulse_on_tick3", ptick, 3);
    btn_magic_n = 1'b1;
    cyc(20);
    wait_phase(5);
    btn_magic_n = 1'b0;
    pulses = 0;
    repeat (3 * 64 + 5) begin
      cyc(1);
      if (reboot_req) pulses++;
    end
    chk("t5_repress_pulse_count", pulses, 1);
    btn_magic_n = 1'b1;
    cyc(20);

    // 6: reset during hotkey hold and mid-debounce
    key_magic = 1'b1;
    cyc(1);
    key_magic = 1'b0;
    btn_pause_n = 1'b0;
    cyc(4);
    chk("t6_magic_before_rst", magic_button, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_magic_async_rst", magic_button, 0);
    chk("t6_pause_async_rst", pause_button, 0);
    chk("t6_reboot_async_rst", reboot_req, 0);
    btn_pause_n = 1'b1;
    cyc(3);
    rst = 1'b0;
    seen = 1'b0;
    repeat (150) begin
      cyc(1);
      seen |= magic_button | pause_button;
    end
    chk("t6_quiet_after_rst", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
